// File: rtl/rgb_encoder_pkg.sv
// Shared definitions for the RGB -> 3-bit colour-code encoder.
//   color_e : the eight palette codes, bit 2 = R, bit 1 = G, bit 0 = B
//   *_BIT   : position of each channel inside a colour code
//   code_t  : one quantised pixel as carried through the pipeline
package rgb_encoder_pkg;

  typedef enum logic [2:0] {
    COLOR_BLACK   = 3'b000,
    COLOR_BLUE    = 3'b001,
    COLOR_GREEN   = 3'b010,
    COLOR_CYAN    = 3'b011,
    COLOR_RED     = 3'b100,
    COLOR_MAGENTA = 3'b101,
    COLOR_YELLOW  = 3'b110,
    COLOR_WHITE   = 3'b111
  } color_e;

  localparam int R_BIT = 2;
  localparam int G_BIT = 1;
  localparam int B_BIT = 0;

  localparam logic [7:0] THRESH_DEFAULT = 8'h80;

  typedef struct packed {
    logic [2:0] color;  // quantised code
    logic       exact;  // every channel was 8'h00 or 8'hFF
  } code_t;

endpackage

// File: rtl/rgb_quant_chan.sv
// Quantises one 8-bit colour channel.
//   i_chan    : channel value (unsigned)
//   o_bit     : 1 when i_chan >= THRESH
//   o_extreme : 1 when i_chan is exactly 8'h00 or 8'hFF
module rgb_quant_chan #(
  parameter logic [7:0] THRESH = 8'h80
) (
  input  logic [7:0] i_chan,
  output logic       o_bit,
  output logic       o_extreme
);

  assign o_bit     = (i_chan >= THRESH);
  assign o_extreme = (i_chan == 8'h00) | (i_chan == 8'hFF);

endmodule

// File: rtl/rgb_encoder.sv
// Streaming RGB888 -> 3-bit colour-code encoder with a two-stage
// valid/ready pipeline and a saturating count of non-palette pixels.
//   clk, rst      : clock, asynchronous active-high reset
//   enable        : 0 freezes intake and the stage A -> B move
//   in_rgb        : {R[23:16], G[15:8], B[7:0]}
//   in_valid/in_ready   : input handshake
//   out_color/out_exact : quantised code and palette-exact flag
//   out_valid/out_ready : output handshake
//   cnt_clr       : synchronous clear of mismatch_cnt (wins over increment)
//   mismatch_cnt  : saturating count of emitted pixels with out_exact = 0
module rgb_encoder
  import rgb_encoder_pkg::*;
#(
  parameter logic [7:0] THRESH = THRESH_DEFAULT,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [23:0]      in_rgb,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       out_color,
  output logic             out_exact,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] mismatch_cnt
);

  logic [2:0] w_color;
  logic [2:0] w_extreme;
  code_t      w_code;

  rgb_quant_chan #(.THRESH(THRESH)) u_quant_r (
    .i_chan    (in_rgb[23:16]),
    .o_bit     (w_color[R_BIT]),
    .o_extreme (w_extreme[R_BIT])
  );

  rgb_quant_chan #(.THRESH(THRESH)) u_quant_g (
    .i_chan    (in_rgb[15:8]),
    .o_bit     (w_color[G_BIT]),
    .o_extreme (w_extreme[G_BIT])
  );

  rgb_quant_chan #(.THRESH(THRESH)) u_quant_b (
    .i_chan    (in_rgb[7:0]),
    .o_bit     (w_color[B_BIT]),
    .o_extreme (w_extreme[B_BIT])
  );

  assign w_code = {w_color, &w_extreme};

  // Pipeline state: stage A holds the freshly quantised pixel, stage B
  // is the output register seen by the consumer.
  logic             r_a_valid;
  code_t            r_a_code;
  logic             r_b_valid;
  code_t            r_b_code;
  logic [CNT_W-1:0] r_cnt;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_a_move;
  logic w_cnt_inc;

  // A may advance when B is empty or is being drained this cycle; A can
  // then accept a new pixel in the same cycle, giving 1 pixel/cycle.
  assign w_a_move   = enable & r_a_valid & (~r_b_valid | out_ready);
  assign in_ready   = enable & ~rst & (~r_a_valid | w_a_move);
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_b_valid & out_ready;
  assign w_cnt_inc  = w_out_xfer & ~r_b_code.exact & (r_cnt != {CNT_W{1'b1}});

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_code  <= '0;
    end else if (w_in_xfer) begin
      r_a_valid <= 1'b1;
      r_a_code  <= w_code;
    end else if (w_a_move) begin
      r_a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      r_b_code  <= '{color: COLOR_BLACK, exact: 1'b0};
    end else if (w_a_move) begin
      r_b_valid <= 1'b1;
      r_b_code  <= r_a_code;
    end else if (w_out_xfer) begin
      r_b_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid    = r_b_valid;
  assign out_color    = r_b_code.color;
  assign out_exact    = r_b_code.exact;
  assign mismatch_cnt = r_cnt;

endmodule
